// File: rtl/pc_fetch_ctrl.sv
// Fetch PC and branch-resolution control for the pipelined core.
// It redirects on branches taken in ID, handles stalls, latches HALT and counts taken branches.
module pc_fetch_ctrl #(
    parameter int                 ADDR_W   = 16,
    parameter int                 PC_INC   = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [15:0]       if_instr,
    input  logic [15:0]       id_instr,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_pc_plus,
    input  logic [ADDR_W-1:0] branch_reg_data,
    input  logic [2:0]        flags,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              flush_if,
    output logic              branch_taken,
    output logic              halted,
    output logic [CNT_W-1:0]  taken_count
);

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Offset is built at least 10 bits wide so a narrow ADDR_W still sees the sign.
    localparam int OFF_W = (ADDR_W > 10) ? ADDR_W : 10;

    typedef struct packed {
        logic       is_b;
        logic       is_br;
        logic [2:0] ccc;
        logic [8:0] imm9;
    } id_dec_t;

    logic [0:0]         state;
    id_dec_t            dec;
    logic               flag_z, flag_n, flag_v;
    logic               cond_true;
    logic               take;
    logic               hlt_in_if;
    logic [OFF_W-1:0]   b_off;
    logic [ADDR_W-1:0]  b_target;
    logic [ADDR_W-1:0]  target;

    always_comb begin
        dec.is_b  = (id_instr[15:12] == OP_B);
        dec.is_br = (id_instr[15:12] == OP_BR);
        dec.ccc   = id_instr[11:9];
        dec.imm9  = id_instr[8:0];
    end

    assign flag_z = flags[0];
    assign flag_n = flags[1];
    assign flag_v = flags[2];

    always_comb begin
        cond_true = 1'b0;
        case (dec.ccc)
            3'b000: cond_true = ~flag_z;
            3'b001: cond_true = flag_z;
            3'b010: cond_true = ~flag_z & ~flag_n;
            3'b011: cond_true = flag_n;
            3'b100: cond_true = flag_z | ~flag_n;
            3'b101: cond_true = flag_n | flag_z;
            3'b110: cond_true = flag_v;
            3'b111: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign b_off    = OFF_W'($signed({dec.imm9, 1'b0}));
    assign b_target = id_pc_plus + b_off[ADDR_W-1:0];
    assign target   = dec.is_br ? branch_reg_data : b_target;

    // Masking with rst keeps the redirect and flush quiet during reset.
    assign take = ~rst & id_valid & ~stall & (state == ST_RUN)
                & (dec.is_b | dec.is_br) & cond_true;

    assign hlt_in_if    = (if_instr[15:12] == OP_HLT);
    assign pc_plus      = pc_addr + ADDR_W'(PC_INC);
    assign branch_taken = take;
    assign flush_if     = take;
    assign halted       = (state == ST_HALT);

    // A taken branch makes the HLT in IF wrong-path, so take is checked before HLT.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_addr <= RESET_PC;
            state   <= ST_RUN;
        end else if (take) begin
            pc_addr <= target;
        end else if (stall) begin
            pc_addr <= pc_addr;
        end else if (state == ST_HALT) begin
            pc_addr <= pc_addr;
        end else if (hlt_in_if) begin
            state   <= ST_HALT;
        end else begin
            pc_addr <= pc_plus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            taken_count <= '0;
        else if (take && (taken_count != {CNT_W{1'b1}}))
            taken_count <= taken_count + 1'b1;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Parametrised program-counter and fetch-control unit for the pipelined core. Replaces the single-cycle PC.
- Holds the fetch PC and computes the sequential PC.
- Resolves conditional/register branches for the instruction in ID and squashes the wrong-path IF instruction.
- Handles hazard stalls and latches a HALT state.
- Keeps a saturating taken-branch counter for performance debug.

Parameters:
- ADDR_W, 16, width of PC, targets and register-branch data.
- PC_INC, 2, sequential increment in bytes.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hazard stall from the hazard unit; holds PC and freezes ID branch resolution.
- if_instr  in  16  instruction currently returned by instruction memory at pc_addr.
- id_instr  in  16  instruction in the IF/ID register.
- id_valid  in  1  id_instr is a real (non-bubble) instruction.
- id_pc_plus  in  ADDR_W  PC+PC_INC of the ID instruction.
- branch_reg_data  in  ADDR_W  rs read data for BR.
- flags  in  3  {V,N,Z}: Z=flags[0], N=flags[1], V=flags[2].
- pc_addr  out  ADDR_W  current fetch address (registered).
- pc_plus  out  ADDR_W  pc_addr+PC_INC (combinational).
- flush_if  out  1  squash the IF/ID load this cycle (taken branch).
- branch_taken  out  1  ID branch resolved taken this cycle.
- halted  out  1  state is HALT.
- taken_count  out  CNT_W  saturating count of taken branches.

Behaviour:
- Instruction decode:
  - Opcode is instr[15:12]: B=4'b1100, BR=4'b1101, HLT=4'b1111.
  - Condition ccc is instr[11:9].
  - B immediate is instr[8:0], signed.
- Condition table:
  - 000 ~Z
  - 001 Z
  - 010 ~Z&~N
  - 011 N
  - 100 Z|~N
  - 101 N|Z
  - 110 V
  - 111 always
- Targets:
  - B target = id_pc_plus + (sext(imm9)<<1), truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - BR target = branch_reg_data.
- Sequential PC: pc_plus = pc_addr + PC_INC, wraps modulo 2^ADDR_W.
- take is high when all of the following hold:
  - id_valid
  - ~stall
  - state==RUN
  - opcode is B or BR
  - the condition is true
- branch_taken = take and flush_if = take; both combinational, same cycle.
- State machine, two states, RUN and HALT:
  - RUN -> HALT when if_instr opcode==HLT, ~take and ~stall.
  - HALT -> RUN only on rst.
- Next-PC priority, evaluated each edge:
  1. rst: pc_addr<=RESET_PC, state<=RUN, taken_count<=0.
  2. take: pc_addr<=target. A HLT in IF is wrong-path, so HALT is not entered.
  3. stall: pc_addr holds, state holds. A pending HLT is evaluated again once stall drops.
  4. state==HALT: pc_addr holds.
  5. HLT detected in IF: pc_addr holds, state<=HALT.
  6. Otherwise: pc_addr<=pc_plus.
- In HALT:
  - flush_if=0, branch_taken=0.
  - Inputs are ignored; the ID slot holds only HLT or older completed work.
- taken_count increments on each edge where take=1 and saturates at all-ones.
- Reset values: pc_addr=RESET_PC, halted=0, taken_count=0. flush_if and branch_taken are 0 while rst is high.
- Latency:
  - Redirect is visible on pc_addr one cycle after take.
  - Exactly one IF instruction is squashed per taken branch.
- Reset mid-operation, including in HALT or during stall: the next edge gives RESET_PC, RUN, count 0.

Test Plan:
- Sequential fetch: rst for 1 cycle, then idle with NOP if_instr -> pc_addr 0x0000, 0x0002, 0x0004, 0x0006; flush_if=0.
- Taken B:
  - Stimulus: id_instr=0xC005 (ccc=000, imm=+5), Z=0, id_pc_plus=0x0010.
  - Response: branch_taken=flush_if=1 that cycle; next pc_addr=0x001A; taken_count=1.
- Not-taken and negative offset:
  - id_instr=0xC3FE (ccc=001, imm=-2) with Z=0 -> pc_addr advances by 2, no flush.
  - Same with Z=1, id_pc_plus=0x0020 -> pc_addr=0x001C.
- BR with stall:
  - Stimulus: id_instr=0xDE00 (ccc=111), branch_reg_data=0x1234, stall=1 for 2 cycles.
  - Response: pc_addr holds and no flush while stalled; the cycle stall drops, branch_taken=1 and next pc_addr=0x1234.
- HLT vs branch:
  - if_instr=0xF000 with a taken B in ID -> redirect wins; halted stays 0.
  - if_instr=0xF000 with no branch -> halted=1 next cycle; pc_addr frozen for 10+ cycles.
  - rst -> pc_addr=0, halted=0.
- Wrap and saturation:
  - pc_addr=0xFFFE -> next pc_addr=0x0000.
  - With CNT_W=2, 5 taken branches -> taken_count=3.
